sw_debouncer: RTL and testbench
===============================

Name: sw_debouncer

Overview:
- Upstream input-conditioning stage for the LED blink/shift top level.
- Takes the raw board slide switches, synchronises each bit to clk, and debounces it with a per-bit timer.
- Outputs stable switch levels, which drive the counter enable/select and the red-LED gate.
- Also outputs one-cycle rise/fall pulses, so a debounced level change can restart the pattern cleanly.

Parameters:
- N_SW, 4: number of switch bits handled; each bit is independent.
- SYNC_STAGES, 2: synchroniser flop depth per bit; legal range is 2 or more.
- DEBOUNCE_CYCLES, 500_000: consecutive steady cycles required to accept a new level (10 ms at 50 MHz); legal range is 2 or more.

Ports:
- clk, input, 1: system clock, rising edge.
- i_rst, input, 1: reset, asynchronous, active-high.
- i_sw, input, N_SW: raw, asynchronous, bouncing switch inputs.
- o_sw, output, N_SW: debounced stable switch levels.
- o_rise, output, N_SW: one-cycle pulse per bit when o_sw goes 0->1.
- o_fall, output, N_SW: one-cycle pulse per bit when o_sw goes 1->0.
- o_change, output, 1: OR of all o_rise and o_fall bits, in the same cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset i_rst is asynchronous and active-high.
- While i_rst=1:
  - all synchroniser flops = 0; o_sw = 0; o_rise = 0; o_fall = 0; o_change = 0.
  - every per-bit FSM is in S_LO; every per-bit counter = 0.
- Synchroniser: s[i] is the output of a SYNC_STAGES-deep flop chain on i_sw[i]. There is no other path from i_sw to logic.
- Per-bit FSM has states S_LO, W_HI, S_HI, W_LO, all registered.
  - S_LO: o_sw[i]=0. If s[i]=1, go to W_HI and clear cnt to 0.
  - W_HI: if s[i]=0, go to S_LO and clear cnt (glitch rejected, no pulse). Otherwise cnt+1. If s[i]=1 while cnt==DEBOUNCE_CYCLES-1, go to S_HI, set o_sw[i]=1 and pulse o_rise[i] for exactly one cycle.
  - S_HI and W_LO mirror S_LO and W_HI with polarity inverted; acceptance in W_LO produces the o_fall[i] pulse.
- Counter:
  - Width is $clog2(DEBOUNCE_CYCLES).
  - It never wraps; it only advances in W_* states.
  - It is cleared on every entry to W_* and on every abort.
- Latency:
  - Hold i_sw[i] at a new level from clock edge 1 (the first edge that samples it).
  - o_sw[i] and the matching pulse update at edge SYNC_STAGES+1+DEBOUNCE_CYCLES.
  - With defaults of 2 and 4 in the bench, that is edge 7.
- Boundary conditions:
  - Any reversal of s[i] during W_* aborts the wait. The toggle-back sample restarts nothing; a subsequent change re-enters W_* with cnt=0.
  - Pulses are registered outputs and are glitch-free. o_rise[i] and o_fall[i] are never both 1.
  - Bits are independent. Simultaneous acceptance on several bits produces simultaneous pulses, and o_change=1 for that single cycle.
  - A switch already high when reset releases is treated as a normal 0->1 change. It is accepted after the full latency and produces o_rise.
  - Reset asserted mid-wait clears immediately (asynchronously) with no pulse. After release, debouncing restarts from S_LO.
  - i_sw steady: no pulses ever; o_sw holds.

Decomposition:
- Shared package (sw_debouncer_pkg) holds:
  - the state encodings S_LO=2'b00, W_HI=2'b01, S_HI=2'b11, W_LO=2'b10;
  - the default constants DEBOUNCE_CYCLES_DEF=500_000 and SYNC_STAGES_DEF=2.
- One sub-module, debounce_bit, contains:
  - the synchroniser chain, FSM, counter and pulse registers for a single bit;
  - parameters SYNC_STAGES and DEBOUNCE_CYCLES;
  - ports clk, i_rst, i_raw, o_level, o_rise, o_fall.
- The top instantiates N_SW copies of debounce_bit with a generate loop and ORs the pulses into o_change.

Test Plan (bench parameters SYNC_STAGES=2, DEBOUNCE_CYCLES=4, N_SW=4):
1. Clean press: i_sw goes 0000->0001 and is held. Required: o_sw=0001 and o_rise=0001 at edge 7, o_change=1 for exactly that cycle, all pulses 0 on the following cycle.
2. Bounce rejection: i_sw[1] toggles 1,0,1,0 every 2 cycles, then stays 0. Required: o_sw[1] stays 0, o_rise and o_fall stay 0 throughout.
3. Bounce then settle: i_sw[2] glitches high for 3 cycles, drops for 1, then holds high. Required: o_rise[2] fires exactly once, 7 edges after the final 0->1 sample.
4. Release with simultaneous events: from o_sw=1111, set i_sw to 0101. Required: o_fall=1010, o_rise=0000, o_change=1 in one single cycle; o_sw=0101 afterwards.
5. Reset mid-wait: assert i_rst 3 cycles into W_HI on bit 0. Required: o_sw=0000 immediately (asynchronously), no pulse. After release with i_sw[0]=1 still held, o_rise[0] fires at edge 7 after the first post-reset edge.
6. Power-on high: hold i_sw=1000 through reset, then release. Required: o_sw=1000 with a single o_rise=1000 pulse at edge 7 after release; no further pulses.

Source files
------------

// File: rtl/sw_debouncer_pkg.sv
// Shared state encodings and default constants for the switch debouncer.
package sw_debouncer_pkg;

    // Per-bit debounce FSM: stable low/high and the two waiting states
    typedef enum logic [1:0] {
        S_LO = 2'b00,
        W_HI = 2'b01,
        S_HI = 2'b11,
        W_LO = 2'b10
    } db_state_e;

    // 10 ms at 50 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500_000;
    localparam int unsigned SYNC_STAGES_DEF     = 2;

endpackage : sw_debouncer_pkg

// File: rtl/sw_debouncer_debounce_bit.sv
// Single-bit synchroniser + debounce FSM with registered level and edge pulses.
module debounce_bit
    import sw_debouncer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    db_state_e              r_state;
    logic [CNT_W-1:0]       r_cnt;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Synchroniser chain: the only path from the raw pin into the logic
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Debounce FSM: a new level must hold for DEBOUNCE_CYCLES samples; any reversal aborts
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_LO;
            r_cnt   <= '0;
            o_level <= 1'b0;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
        end else begin
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            case (r_state)
                S_LO: begin
                    if (w_s) begin
                        r_state <= W_HI;
                        r_cnt   <= '0;
                    end
                end
                W_HI: begin
                    if (!w_s) begin
                        r_state <= S_LO;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_HI;
                        r_cnt   <= '0;
                        o_level <= 1'b1;
                        o_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HI: begin
                    if (!w_s) begin
                        r_state <= W_LO;
                        r_cnt   <= '0;
                    end
                end
                W_LO: begin
                    if (w_s) begin
                        r_state <= S_HI;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_LO;
                        r_cnt   <= '0;
                        o_level <= 1'b0;
                        o_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_LO;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule : debounce_bit

// File: rtl/sw_debouncer.sv
// Board slide-switch conditioner: N_SW independent debounced bits plus edge pulses.
module sw_debouncer
    import sw_debouncer_pkg::*;
#(
    parameter int unsigned N_SW            = 4,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            i_rst,
    input  logic [N_SW-1:0] i_sw,
    output logic [N_SW-1:0] o_sw,
    output logic [N_SW-1:0] o_rise,
    output logic [N_SW-1:0] o_fall,
    output logic            o_change
);

    // One debouncer per switch bit
    for (genvar g = 0; g < int'(N_SW); g++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .i_rst  (i_rst),
            .i_raw  (i_sw[g]),
            .o_level(o_sw[g]),
            .o_rise (o_rise[g]),
            .o_fall (o_fall[g])
        );
    end

    // Any debounced edge on any bit; pulses are flops so this is glitch-free
    assign o_change = |(o_rise | o_fall);

endmodule : sw_debouncer

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4 (accept at edge 7).
module tb_sw_debouncer;

    logic       clk;
    logic       i_rst;
    logic [3:0] i_sw;
    logic [3:0] o_sw;
    logic [3:0] o_rise;
    logic [3:0] o_fall;
    logic       o_change;

    int n_tests;
    int n_fail;

    // observed vector: {o_sw, o_rise, o_fall, o_change}
    wire [12:0] obs = {o_sw, o_rise, o_fall, o_change};

    sw_debouncer #(
        .N_SW           (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_sw    (i_sw),
        .o_sw    (o_sw),
        .o_rise  (o_rise),
        .o_fall  (o_fall),
        .o_change(o_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] exp;
        i_rst = 1'b1;
        i_sw  = 4'b0000;
        tick();
        tick();
        exp = 13'b0;
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_hold: got %b want %b", obs, exp);
        end
        i_rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_steady k=%0d: got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [12:0] exp;
        i_sw = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 7)       exp = {4'b0000, 4'b0000, 4'b0000, 1'b0};
            else if (k == 7) exp = {4'b0001, 4'b0001, 4'b0000, 1'b1};
            else             exp = {4'b0001, 4'b0000, 4'b0000, 1'b0};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL clean_press edge=%0d: got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_bounce_reject();
        logic [12:0] exp;
        exp = {4'b0001, 4'b0000, 4'b0000, 1'b0};
        for (int k = 0; k < 20; k++) begin
            i_sw[1] = (k < 2) ? 1'b1 : (k < 4) ? 1'b0 : (k < 6) ? 1'b1 : 1'b0;
            tick();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL bounce_reject k=%0d: got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_bounce_settle();
        logic [12:0] exp;
        exp = {4'b0001, 4'b0000, 4'b0000, 1'b0};
        for (int k = 0; k < 4; k++) begin
            i_sw[2] = (k < 3) ? 1'b1 : 1'b0;
            tick();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL settle_glitch k=%0d: got %b want %b", k, obs, exp);
            end
        end
        i_sw[2] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k < 7)       exp = {4'b0001, 4'b0000, 4'b0000, 1'b0};
            else if (k == 7) exp = {4'b0101, 4'b0100, 4'b0000, 1'b1};
            else             exp = {4'b0101, 4'b0000, 4'b0000, 1'b0};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL settle_final edge=%0d: got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [12:0] exp;
        i_sw = 4'b1111;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 7)       exp = {4'b0101, 4'b0000, 4'b0000, 1'b0};
            else if (k == 7) exp = {4'b1111, 4'b1010, 4'b0000, 1'b1};
            else             exp = {4'b1111, 4'b0000, 4'b0000, 1'b0};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL simul_rise edge=%0d: got %b want %b", k, obs, exp);
            end
        end
        i_sw = 4'b0101;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k < 7)       exp = {4'b1111, 4'b0000, 4'b0000, 1'b0};
            else if (k == 7) exp = {4'b0101, 4'b0000, 4'b1010, 1'b1};
            else             exp = {4'b0101, 4'b0000, 4'b0000, 1'b0};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL simul_fall edge=%0d: got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [12:0] exp;
        i_sw = 4'b0100;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 7)       exp = {4'b0101, 4'b0000, 4'b0000, 1'b0};
            else if (k == 7) exp = {4'b0100, 4'b0000, 4'b0001, 1'b1};
            else             exp = {4'b0100, 4'b0000, 4'b0000, 1'b0};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL midrst_prep edge=%0d: got %b want %b", k, obs, exp);
            end
        end
        // bit 0 enters W_HI at edge 3; reset lands three cycles into the wait
        i_sw = 4'b0101;
        exp  = {4'b0100, 4'b0000, 4'b0000, 1'b0};
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL midrst_wait edge=%0d: got %b want %b", k, obs, exp);
            end
        end
        i_rst = 1'b1;
        #1;
        exp = 13'b0;
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL midrst_async: got %b want %b", obs, exp);
        end
        for (int k = 1; k <= 2; k++) begin
            tick();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL midrst_hold k=%0d: got %b want %b", k, obs, exp);
            end
        end
        i_rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k < 7)       exp = {4'b0000, 4'b0000, 4'b0000, 1'b0};
            else if (k == 7) exp = {4'b0101, 4'b0101, 4'b0000, 1'b1};
            else             exp = {4'b0101, 4'b0000, 4'b0000, 1'b0};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL midrst_after edge=%0d: got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_power_on_high();
        logic [12:0] exp;
        i_sw  = 4'b1000;
        i_rst = 1'b1;
        #1;
        exp = 13'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL poweron_hold k=%0d: got %b want %b", k, obs, exp);
            end
        end
        i_rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k < 7)       exp = {4'b0000, 4'b0000, 4'b0000, 1'b0};
            else if (k == 7) exp = {4'b1000, 4'b1000, 4'b0000, 1'b1};
            else             exp = {4'b1000, 4'b0000, 4'b0000, 1'b0};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL poweron edge=%0d: got %b want %b", k, obs, exp);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        i_rst   = 1'b1;
        i_sw    = 4'b0000;
        test_reset();
        test_clean_press();
        test_bounce_reject();
        test_bounce_settle();
        test_simultaneous();
        test_reset_mid_wait();
        test_power_on_high();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sw_debouncer
